fft_result_reader: RTL and testbench

Reads a completed FFT frame out of the FFT result RAM after the butterfly stages finish. It fetches the positive-frequency bins (0 … N/2-1) in natural order and computes an L1 magnitude (|re|+|im|) for each bin. Each bin is streamed downstream over a valid/ready handshake. The block also tracks the peak non-DC bin for the tuner's pitch logic, sitting between the FFT core's result memory and the note-detection stage.

---
 rtl/fft_result_reader.sv | 152 +++++++++++++++
 tb/tb_fft_result_reader.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_result_reader.sv
// fft_result_reader
// Streams the positive-frequency bins of a finished FFT frame out of the
// result RAM in natural order, one bin per three cycles, each tagged with
// its L1 magnitude, and records the strongest non-DC bin for pitch logic.

module fft_result_reader #(
  parameter int BIT_WIDTH = 16,
  parameter int L         = 11
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic                   rd_en,
  output logic [L-1:0]           rd_addr,
  input  logic [2*BIT_WIDTH-1:0] rd_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [L-1:0]           out_bin,
  output logic [BIT_WIDTH:0]     out_mag,
  output logic                   busy,
  output logic                   done,
  output logic [L-1:0]           peak_bin,
  output logic [BIT_WIDTH:0]     peak_mag
);

  // Highest bin index read per frame: N/2 - 1
  localparam logic [L-1:0] LAST_BIN = {1'b0, {(L-1){1'b1}}};

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    PRESENT,
    DONE
  } state_t;

  state_t state, state_next;

  logic [L-1:0]            bin_cnt;
  logic [L-1:0]            run_bin;
  logic [BIT_WIDTH:0]      run_mag;
  logic signed [BIT_WIDTH:0] re_ext, im_ext;
  logic [BIT_WIDTH:0]      re_abs, im_abs, mag_sum;
  logic                    handshake;

  // The address bus follows the bin counter; the counter only moves on a
  // handshake or a new start, so the address holds outside FETCH.
  assign rd_addr   = bin_cnt;
  assign handshake = (state == PRESENT) && out_ready;

  // L1 magnitude of the word on the read bus; one extra bit makes |-2^(W-1)| exact
  always_comb begin
    re_ext  = {rd_data[2*BIT_WIDTH-1], rd_data[2*BIT_WIDTH-1:BIT_WIDTH]};
    im_ext  = {rd_data[BIT_WIDTH-1], rd_data[BIT_WIDTH-1:0]};
    re_abs  = re_ext[BIT_WIDTH] ? $unsigned(-re_ext) : $unsigned(re_ext);
    im_abs  = im_ext[BIT_WIDTH] ? $unsigned(-im_ext) : $unsigned(im_ext);
    mag_sum = re_abs + im_abs;
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and state-decoded control outputs
  always_comb begin
    state_next = state;
    rd_en      = 1'b0;
    out_valid  = 1'b0;
    done       = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) begin
          state_next = FETCH;
        end
      end
      FETCH: begin
        rd_en      = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        state_next = PRESENT;
      end
      PRESENT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = (bin_cnt == LAST_BIN) ? DONE : FETCH;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Bin counter: cleared at frame start, advanced after each accepted non-final beat
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bin_cnt <= '0;
    end else if (state == IDLE && start) begin
      bin_cnt <= '0;
    end else if (handshake && bin_cnt != LAST_BIN) begin
      bin_cnt <= bin_cnt + 1'b1;
    end
  end

  // Output beat register, loaded in the cycle the RAM data is on the bus
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_bin <= '0;
      out_mag <= '0;
    end else if (state == WAIT) begin
      out_bin <= bin_cnt;
      out_mag <= mag_sum;
    end
  end

  // Running peak over accepted non-DC beats; strict compare keeps the lower bin on ties
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_bin <= '0;
      run_mag <= '0;
    end else if (state == IDLE && start) begin
      run_bin <= '0;
      run_mag <= '0;
    end else if (handshake && out_bin != '0 && out_mag > run_mag) begin
      run_bin <= out_bin;
      run_mag <= out_mag;
    end
  end

  // Published peak only changes once a frame has been fully streamed
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      peak_bin <= '0;
      peak_mag <= '0;
    end else if (state == DONE) begin
      peak_bin <= run_bin;
      peak_mag <= run_mag;
    end
  end

endmodule

// File: tb/tb_fft_result_reader.sv
// tb_fft_result_reader
// Directed frames against a behavioural result RAM; expected magnitudes,
// peaks and cycle positions are worked out by hand or by a small L1 model.

module tb_fft_result_reader;

  localparam int BW    = 16;
  localparam int L     = 11;
  localparam int NBINS = 1024;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             rd_en;
  logic [L-1:0]     rd_addr;
  logic [2*BW-1:0]  rd_data;
  logic             out_valid;
  logic             out_ready;
  logic [L-1:0]     out_bin;
  logic [BW:0]      out_mag;
  logic             busy;
  logic             done;
  logic [L-1:0]     peak_bin;
  logic [BW:0]      peak_mag;

  logic [2*BW-1:0]  ram [0:NBINS-1];
  int               got_mag [0:NBINS-1];
  int               cyc = 0;
  int               check_count = 0;
  int               pass_count = 0;
  int               model_peak_bin = 0;
  int               model_peak_mag = 0;

  fft_result_reader #(.BIT_WIDTH(BW), .L(L)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bin   (out_bin),
    .out_mag   (out_mag),
    .busy      (busy),
    .done      (done),
    .peak_bin  (peak_bin),
    .peak_mag  (peak_mag)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Result RAM with one-cycle synchronous read
  always @(posedge clk) begin
    if (rd_en) rd_data <= ram[rd_addr];
  end

  // Cycle counter used to timestamp events relative to the start edge
  always @(posedge clk) begin
    cyc <= cyc + 1;
  end

  // Hard stop in case the design wedges outside a bounded loop
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    check_count++;
    if (observed == expected) pass_count++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
  endtask

  function automatic int l1(input logic [31:0] w);
    int re, im;
    re = int'($signed(w[31:16]));
    im = int'($signed(w[15:0]));
    return ((re < 0) ? -re : re) + ((im < 0) ? -im : im);
  endfunction

  task automatic clearRam();
    for (int i = 0; i < NBINS; i++) ram[i] = '0;
  endtask

  task automatic setBin(input int idx, input int re, input int im);
    ram[idx] = {re[15:0], im[15:0]};
  endtask

  // Runs one frame from a start pulse; called #1 after a rising edge.
  task automatic applyStimulus(input string name, input int stall_bin, input int stall_n,
                               input int inject_rel, input int abort_bin,
                               input int exp_pb, input int exp_pm, input int exp_done);
    int  k0, rel, beats, order_err, mag_err, held_err, stall_err, stalls, reads;
    int  first_valid, done_rel, busy_fall, stall_left;
    bit  finished;
    beats = 0; order_err = 0; mag_err = 0; held_err = 0; stall_err = 0;
    stalls = 0; reads = 0; first_valid = -1; done_rel = -1; busy_fall = -1;
    stall_left = stall_n; finished = 0;
    for (int i = 0; i < NBINS; i++) got_mag[i] = -1;

    start = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k0 = cyc;
    for (int n = 0; n < 4000 && !finished; n++) begin
      if (n > 0) begin
        @(posedge clk); #1;
      end
      rel = cyc - k0 + 1;
      start = (inject_rel > 0 && (rel == inject_rel || rel == inject_rel + 301)) ? 1'b1 : 1'b0;
      if (rel == 1) begin
        checkOutput({name, ".fetch_rd_en"}, rd_en, 1);
        checkOutput({name, ".fetch_rd_addr"}, rd_addr, 0);
      end
      if (rd_en) reads++;
      if (out_valid && first_valid < 0) first_valid = rel;
      if (done_rel < 0 && (peak_bin != model_peak_bin || peak_mag != model_peak_mag)) held_err++;
      if (out_valid && out_bin == stall_bin && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
        stalls++;
        if (out_mag != l1(ram[stall_bin]) || rd_en) stall_err++;
      end else begin
        out_ready = 1'b1;
      end
      if (abort_bin >= 0 && out_valid && out_bin == abort_bin) begin
        reset = 1'b0;
        #1;
        checkOutput({name, ".abort_rd_en"}, rd_en, 0);
        checkOutput({name, ".abort_rd_addr"}, rd_addr, 0);
        checkOutput({name, ".abort_out_valid"}, out_valid, 0);
        checkOutput({name, ".abort_out_bin"}, out_bin, 0);
        checkOutput({name, ".abort_out_mag"}, out_mag, 0);
        checkOutput({name, ".abort_busy"}, busy, 0);
        checkOutput({name, ".abort_done"}, done, 0);
        checkOutput({name, ".abort_peak_bin"}, peak_bin, 0);
        checkOutput({name, ".abort_peak_mag"}, peak_mag, 0);
        finished = 1;
      end else begin
        if (out_valid && out_ready) begin
          if (out_bin != beats) order_err++;
          got_mag[out_bin] = int'(out_mag);
          if (int'(out_mag) != l1(ram[out_bin])) mag_err++;
          beats++;
        end
        if (done && done_rel < 0) begin
          done_rel = rel;
        end else if (done_rel >= 0 && rel == done_rel + 1) begin
          busy_fall = busy ? -1 : rel;
          checkOutput({name, ".peak_bin"}, peak_bin, exp_pb);
          checkOutput({name, ".peak_mag"}, peak_mag, exp_pm);
          finished = 1;
        end
      end
    end
    checkOutput({name, ".finished"}, finished, 1);
    out_ready = 1'b1;
    start = 1'b0;
    if (abort_bin >= 0) begin
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      model_peak_bin = 0;
      model_peak_mag = 0;
      return;
    end
    checkOutput({name, ".beats"}, beats, NBINS);
    checkOutput({name, ".order_err"}, order_err, 0);
    checkOutput({name, ".mag_err"}, mag_err, 0);
    checkOutput({name, ".first_valid"}, first_valid, 3);
    checkOutput({name, ".done_cycle"}, done_rel, exp_done);
    checkOutput({name, ".busy_fall"}, busy_fall, exp_done + 1);
    checkOutput({name, ".peak_held"}, held_err, 0);
    checkOutput({name, ".reads"}, reads, NBINS);
    checkOutput({name, ".stalls"}, stalls, stall_n);
    checkOutput({name, ".stall_err"}, stall_err, 0);
    model_peak_bin = exp_pb;
    model_peak_mag = exp_pm;
  endtask

  // Test sequence
  initial begin
    int rst_err, idle_err;
    reset = 1'b0;
    start = 1'b0;
    out_ready = 1'b0;
    clearRam();
    rst_err = 0;
    idle_err = 0;

    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      start = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (rd_en || rd_addr != 0 || out_valid || out_bin != 0 || out_mag != 0 ||
          busy || done || peak_bin != 0 || peak_mag != 0) rst_err++;
    end
    checkOutput("reset.outputs", rst_err, 0);
    checkOutput("reset.busy", busy, 0);

    @(posedge clk); #1;
    start = 1'b0;
    out_ready = 1'b1;
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (busy || rd_en || out_valid || done) idle_err++;
    end
    checkOutput("idle.no_activity", idle_err, 0);

    $display("[TB] single tone");
    clearRam();
    setBin(37, 1000, -500);
    applyStimulus("tone", -1, 0, -1, -1, 37, 1500, 3073);
    checkOutput("tone.mag37", got_mag[37], 1500);
    checkOutput("tone.mag36", got_mag[36], 0);

    $display("[TB] dc exclusion and ties");
    clearRam();
    setBin(0, 30000, 30000);
    setBin(5, 10, 0);
    setBin(8, 0, -10);
    applyStimulus("dc", -1, 0, -1, -1, 5, 10, 3073);
    checkOutput("dc.mag0", got_mag[0], 60000);
    checkOutput("dc.mag8", got_mag[8], 10);

    $display("[TB] extremes");
    clearRam();
    setBin(9, -32768, -32768);
    setBin(12, -32768, -32768);
    applyStimulus("ext", -1, 0, -1, -1, 9, 65536, 3073);
    checkOutput("ext.mag9", got_mag[9], 65536);
    checkOutput("ext.mag12", got_mag[12], 65536);

    $display("[TB] all-zero frame");
    clearRam();
    applyStimulus("zero", -1, 0, -1, -1, 0, 0, 3073);

    $display("[TB] backpressure");
    clearRam();
    setBin(3, 100, -200);
    applyStimulus("bp", 3, 5, -1, -1, 3, 300, 3078);
    checkOutput("bp.mag3", got_mag[3], 300);

    $display("[TB] start during frame");
    clearRam();
    setBin(37, 1000, -500);
    applyStimulus("restart", -1, 0, 100, -1, 37, 1500, 3073);

    $display("[TB] reset mid-frame");
    setBin(700, -4000, 123);
    applyStimulus("abort", -1, 0, -1, 200, 0, 0, 0);

    $display("[TB] frame after reset");
    applyStimulus("after", -1, 0, -1, -1, 700, 4123, 3073);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
